cavlc_fifo_ctrl: RTL and testbench

Pointer/flag controller for the 8-entry x 16-bit CAVLC FIFO memory. It converts a valid/ready push interface and a valid/ready pop interface into the memory's write address, read address, write enable and read enable. It tracks occupancy and supports a synchronous flush. It sits between the coefficient/token producer and the CAVLC bitstream packer, with the FIFO memory instance as its only storage.

---
 rtl/cavlc_fifo_ctrl.sv | 86 ++++++++
 tb/tb_cavlc_fifo_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cavlc_fifo_ctrl.sv
// cavlc_fifo_ctrl: pointer/flag controller for the CAVLC coefficient FIFO.
// Converts valid/ready push and pop handshakes into write/read strobes and
// addresses for an external memory whose read port is combinational.
// The only state is two wrap-bit pointers. Occupancy and flags come from them.
module cavlc_fifo_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 3,
    parameter int ALMOST_FULL = 6
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Flush,
    input  logic                  InValid,
    input  logic [DATA_WIDTH-1:0] InData,
    output logic                  InReady,
    output logic                  OutValid,
    output logic [DATA_WIDTH-1:0] OutData,
    input  logic                  OutReady,
    output logic [ADDR_WIDTH-1:0] MemAddrWrite,
    output logic [ADDR_WIDTH-1:0] MemAddrRead,
    output logic [DATA_WIDTH-1:0] MemDataIn,
    output logic                  MemWE,
    output logic                  MemOE,
    input  logic [DATA_WIDTH-1:0] MemDataOut,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Empty,
    output logic                  Full,
    output logic                  AlmostFull
);

    localparam int                PW      = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] PTR_ONE = PW'(1);
    localparam logic [ADDR_WIDTH:0] AF_LVL  = PW'(ALMOST_FULL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                push, pop;

    // Occupancy flags and handshakes. Flush blocks both sides for its cycle.
    always_comb begin
        Count      = wr_ptr_q - rd_ptr_q;
        Empty      = (wr_ptr_q == rd_ptr_q);
        Full       = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                     (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
        AlmostFull = (Count >= AF_LVL);
        InReady    = !Full && !Flush;
        OutValid   = !Empty && !Flush;
        push       = InValid && InReady;
        pop        = OutValid && OutReady;
    end

    // Memory drive. The head word falls straight through from the read port.
    always_comb begin
        MemWE        = push;
        MemAddrWrite = wr_ptr_q[ADDR_WIDTH-1:0];
        MemDataIn    = InData;
        MemOE        = !Empty;
        MemAddrRead  = rd_ptr_q[ADDR_WIDTH-1:0];
        OutData      = OutValid ? MemDataOut : '0;
    end

    // Next pointers. Flush returns both to zero. Otherwise each advances on its handshake.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers. Reset is asynchronous and discards all contents.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: tb/tb_cavlc_fifo_ctrl.sv
// Directed bench for cavlc_fifo_ctrl with a behavioural 8x16 memory model.
module tb_cavlc_fifo_ctrl;

    logic        Clk = 1'b0;
    logic        Reset, Flush, InValid, OutReady;
    logic [15:0] InData;
    logic        InReady, OutValid, MemWE, MemOE, Empty, Full, AlmostFull;
    logic [15:0] OutData, MemDataIn, MemDataOut;
    logic [2:0]  MemAddrWrite, MemAddrRead;
    logic [3:0]  Count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] mem [8];

    always #5 Clk = ~Clk;

    // Memory: synchronous write, combinational read.
    always_ff @(posedge Clk) if (MemWE) mem[MemAddrWrite] <= MemDataIn;
    assign MemDataOut = mem[MemAddrRead];

    cavlc_fifo_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ALMOST_FULL(6)) dut (
        .Clk(Clk), .Reset(Reset), .Flush(Flush),
        .InValid(InValid), .InData(InData), .InReady(InReady),
        .OutValid(OutValid), .OutData(OutData), .OutReady(OutReady),
        .MemAddrWrite(MemAddrWrite), .MemAddrRead(MemAddrRead),
        .MemDataIn(MemDataIn), .MemWE(MemWE), .MemOE(MemOE),
        .MemDataOut(MemDataOut), .Count(Count),
        .Empty(Empty), .Full(Full), .AlmostFull(AlmostFull)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Flush = 0; InValid = 0; OutReady = 0; InData = '0;
        #3;
        Reset = 1'b0;
        step();
        n_cmp++; if (InReady !== 1'b1) begin n_err++; $display("FAIL rst_inready got %b exp 1", InReady); end
        n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL rst_outvalid got %b exp 0", OutValid); end
        n_cmp++; if (OutData !== 16'h0) begin n_err++; $display("FAIL rst_outdata got %h exp 0000", OutData); end
        n_cmp++; if (Count !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d exp 0", Count); end
        n_cmp++; if ({Empty, Full, AlmostFull} !== 3'b100) begin n_err++; $display("FAIL rst_flags got %b exp 100", {Empty, Full, AlmostFull}); end
        n_cmp++; if ({MemWE, MemOE} !== 2'b00) begin n_err++; $display("FAIL rst_mem_en got %b exp 00", {MemWE, MemOE}); end
        n_cmp++; if ({MemAddrWrite, MemAddrRead} !== 6'd0) begin n_err++; $display("FAIL rst_addr got %h exp 00", {MemAddrWrite, MemAddrRead}); end
    endtask

    task automatic test_fill();
        OutReady = 0;
        for (int i = 1; i <= 8; i++) begin
            InValid = 1; InData = 16'(i);
            #1;
            n_cmp++; if (MemWE !== 1'b1 || MemAddrWrite !== 3'(i - 1)) begin n_err++; $display("FAIL fill_we[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, MemWE, MemAddrWrite, i - 1); end
            step();
            n_cmp++; if (Count !== 4'(i)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, Count, i); end
            n_cmp++; if (AlmostFull !== (i >= 6)) begin n_err++; $display("FAIL fill_af[%0d] got %b exp %b", i, AlmostFull, i >= 6); end
            n_cmp++; if (Full !== (i == 8)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, Full, i == 8); end
        end
        InData = 16'hDEAD;
        #1;
        n_cmp++; if ({InReady, MemWE} !== 2'b00) begin n_err++; $display("FAIL full_block got rdy/we=%b exp 00", {InReady, MemWE}); end
        step();
        InValid = 0;
        n_cmp++; if (Count !== 4'd8) begin n_err++; $display("FAIL full_count got %0d exp 8", Count); end
    endtask

    task automatic test_drain();
        OutReady = 1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            n_cmp++; if (OutValid !== 1'b1 || OutData !== 16'(i)) begin n_err++; $display("FAIL drain_data[%0d] got v=%b d=%h exp v=1 d=%h", i, OutValid, OutData, 16'(i)); end
            step();
            n_cmp++; if (Count !== 4'(8 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, Count, 8 - i); end
        end
        n_cmp++; if ({Empty, OutValid, MemOE} !== 3'b100) begin n_err++; $display("FAIL drain_empty got e/v/oe=%b exp 100", {Empty, OutValid, MemOE}); end
        OutReady = 0;
    endtask

    task automatic test_stream();
        // Pointers start at 8 (low bits 0). Prime with one entry at address 0.
        InValid = 1; InData = 16'h0100; OutReady = 0;
        step();
        for (int k = 0; k < 20; k++) begin
            InValid = 1; OutReady = 1; InData = 16'h0101 + 16'(k);
            #1;
            n_cmp++; if (OutData !== 16'h0100 + 16'(k)) begin n_err++; $display("FAIL stream_data[%0d] got %h exp %h", k, OutData, 16'h0100 + 16'(k)); end
            n_cmp++; if (MemAddrWrite !== 3'(k + 1) || MemAddrRead !== 3'(k)) begin n_err++; $display("FAIL stream_addr[%0d] got w=%0d r=%0d exp w=%0d r=%0d", k, MemAddrWrite, MemAddrRead, (k + 1) % 8, k % 8); end
            step();
            n_cmp++; if (Count !== 4'd1) begin n_err++; $display("FAIL stream_count[%0d] got %0d exp 1", k, Count); end
        end
        InValid = 0; OutReady = 1;
        #1;
        n_cmp++; if (OutData !== 16'h0114) begin n_err++; $display("FAIL stream_last got %h exp 0114", OutData); end
        step();
        OutReady = 0;
        n_cmp++; if (Empty !== 1'b1) begin n_err++; $display("FAIL stream_empty got %b exp 1", Empty); end
    endtask

    task automatic test_no_bypass();
        InValid = 1; InData = 16'hAAAA;
        #1;
        n_cmp++; if (OutValid !== 1'b0) begin n_err++; $display("FAIL bypass_same_cycle got %b exp 0", OutValid); end
        step();
        InValid = 0;
        n_cmp++; if (OutValid !== 1'b1 || OutData !== 16'hAAAA) begin n_err++; $display("FAIL bypass_next got v=%b d=%h exp v=1 d=aaaa", OutValid, OutData); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) begin
            InValid = 1; InData = 16'h0B00 + 16'(i);
            step();
        end
        InValid = 0;
        n_cmp++; if (Count !== 4'd5) begin n_err++; $display("FAIL flush_pre_count got %0d exp 5", Count); end
        Flush = 1; InValid = 1; InData = 16'h1234; OutReady = 1;
        #1;
        n_cmp++; if ({MemWE, InReady, OutValid} !== 3'b000) begin n_err++; $display("FAIL flush_block got we/rdy/v=%b exp 000", {MemWE, InReady, OutValid}); end
        step();
        Flush = 0; InValid = 0; OutReady = 0;
        n_cmp++; if (Count !== 4'd0 || Empty !== 1'b1) begin n_err++; $display("FAIL flush_clear got cnt=%0d e=%b exp cnt=0 e=1", Count, Empty); end
        InValid = 1; InData = 16'h5678;
        #1;
        n_cmp++; if (MemWE !== 1'b1 || MemAddrWrite !== 3'd0) begin n_err++; $display("FAIL flush_repush got we=%b addr=%0d exp we=1 addr=0", MemWE, MemAddrWrite); end
        step();
        InValid = 0;
        n_cmp++; if (OutData !== 16'h5678 || Count !== 4'd1) begin n_err++; $display("FAIL flush_head got d=%h cnt=%0d exp d=5678 cnt=1", OutData, Count); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            InValid = 1; InData = 16'h0C00 + 16'(i);
            step();
        end
        InValid = 0;
        n_cmp++; if (Count !== 4'd4) begin n_err++; $display("FAIL areset_pre_count got %0d exp 4", Count); end
        #1 Reset = 1;
        #1;
        n_cmp++; if (Count !== 4'd0 || Empty !== 1'b1 || OutData !== 16'h0) begin n_err++; $display("FAIL areset_now got cnt=%0d e=%b d=%h exp cnt=0 e=1 d=0000", Count, Empty, OutData); end
        #1 Reset = 0;
        InValid = 1; InData = 16'h9999;
        #1;
        n_cmp++; if (MemWE !== 1'b1 || MemAddrWrite !== 3'd0) begin n_err++; $display("FAIL areset_push got we=%b addr=%0d exp we=1 addr=0", MemWE, MemAddrWrite); end
        step();
        InValid = 0; OutReady = 1;
        #1;
        n_cmp++; if (OutValid !== 1'b1 || OutData !== 16'h9999) begin n_err++; $display("FAIL areset_head got v=%b d=%h exp v=1 d=9999", OutValid, OutData); end
        step();
        OutReady = 0;
        n_cmp++; if (Empty !== 1'b1) begin n_err++; $display("FAIL areset_pop got e=%b exp 1", Empty); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = '0;
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_no_bypass();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
